jtag_tap_param: RTL
===================

Name: jtag_tap_param

Overview:
Parametrised JTAG test access port that combines the 16-state TAP controller, a configurable-width instruction register and a bank of data registers into one block. The bank holds BYPASS, IDCODE and NUM_USER_DR user registers. The block replaces the fixed 4-bit IR / single-DR arrangement and adds TDO output muxing and capture/update interfaces to core logic. It sits at the chip boundary between the pins and the debug/test logic.

Parameters:
IR_WIDTH, 4, instruction register width (min 2)
IDCODE_VAL, 32'h1000_0001, value captured by IDCODE; bit 0 must be 1
NUM_USER_DR, 2, number of user data registers (1..8)
USER_DR_WIDTH, 8, width of each user data register (min 1)

Ports:
TCK  in  1  test clock, sole clock of the block
TRST  in  1  asynchronous active-low reset
TMS  in  1  mode select, sampled on rising TCK
TDI  in  1  serial data in, sampled on rising TCK
TDO  out  1  serial data out, changes on falling TCK
TDO_EN  out  1  high while in Shift-IR or Shift-DR (registered on falling TCK)
JTAG_IR  out  IR_WIDTH  current (updated) instruction
user_capture  in  NUM_USER_DR*USER_DR_WIDTH  parallel data loaded in Capture-DR; slice i is for USERi
user_update  out  NUM_USER_DR*USER_DR_WIDTH  holding registers written in Update-DR
user_update_stb  out  NUM_USER_DR  one-TCK pulse; bit i is set when slice i was updated

Behaviour:
- Reset is asynchronous (TRST=0). It forces the following values:
  - state = Test-Logic-Reset
  - JTAG_IR = IDCODE opcode (1)
  - TDO = 0, TDO_EN = 0
  - user_update = 0, user_update_stb = 0
  - all shift registers = 0
- Entering Test-Logic-Reset through TMS (five TMS=1 clocks from any state) has the same effect as TRST, except that user_update keeps its value.
- TAP FSM: standard IEEE 1149.1 16-state graph. Transitions occur on rising TCK per TMS. States:
  - TLR, RTI
  - SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR
  - SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR
- Opcodes:
  - 0 is EXTEST-reserved and decodes as BYPASS.
  - 1 is IDCODE.
  - 2..NUM_USER_DR+1 select USER0..USERn.
  - All-ones is BYPASS.
  - Any other value decodes as BYPASS.
- IR path:
  - CapIR loads the shift register with {0..0,2'b01}.
  - ShIR shifts right: TDI enters the MSB, the LSB goes to the TDO mux.
  - UpdIR copies the shift register to JTAG_IR.
  - JTAG_IR never changes outside UpdIR or reset.
- DR path, selected by the decoded JTAG_IR. On the rising edge while in the relevant state:
  - CapDR: BYPASS loads 0; IDCODE loads IDCODE_VAL; USERi loads slice i of user_capture.
  - ShDR: the selected register shifts right with TDI into its MSB. Unselected registers hold.
  - UpdDR: USERi copies its shift register to slice i of user_update and pulses user_update_stb[i] for exactly one TCK. BYPASS and IDCODE have no update effect.
- TDO:
  - Registered on falling TCK from the LSB of the active shift register (IR in ShIR, selected DR in ShDR). Otherwise TDO = 0.
  - TDO_EN is registered on the same falling edge.
  - Net effect: the first TDO bit is valid on the falling edge after entering a Shift state. A DR of N bits needs N ShDR clocks; the last is the clock that exits on TMS=1.
- Pause states hold all shift contents. Ex2→Shift resumes shifting without recapture.
- Widths: the BYPASS path is 1 bit, so TDI reappears on TDO one clock later. IDCODE is 32 bits.
- Reset mid-shift: TRST aborts immediately. No update strobe is generated and user_update keeps its pre-reset value only if reset came via TMS; TRST clears it.
- An IR update to a new instruction while a DR holds partially shifted data does not corrupt user_update.

Test Plan:
- TRST pulse low, then shift 32 bits via CapDR/ShDR without IR load -> TDO emits IDCODE_VAL LSB-first (1,0,0,0... for 32'h1000_0001); JTAG_IR=1.
- From RTI drive TMS=1 five times from ShDR mid-shift -> state TLR, JTAG_IR=1, no user_update_stb pulse.
- Load IR=4'hF, shift DR pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-bit BYPASS delay, first bit is the captured 0).
- Load IR=4'h2, user_capture slice0=8'hA5, shift in 8'h3C -> TDO outputs A5 LSB-first; at UpdDR user_update[7:0]=8'h3C and user_update_stb=2'b01 for one TCK.
- ShIR after CapIR with IR_WIDTH=4 -> first two TDO bits 1,0; reading unused opcode 4'h7 -> DR behaves as BYPASS.
- Enter PauseDR mid-USER1 shift for 5 clocks, resume via Ex2DR -> shifted data contiguous, no recapture, update value correct.

Source files
------------

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: IEEE 1149.1 TAP controller with a parametrised instruction
// register and a data register bank of BYPASS, IDCODE and NUM_USER_DR user
// registers. Each user register has a parallel capture input and an update
// holding register with a one-TCK strobe toward core logic.
module jtag_tap_param #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001,
  parameter int          NUM_USER_DR   = 2,
  parameter int          USER_DR_WIDTH = 8
) (
  input  logic                                   TCK,
  input  logic                                   TRST,
  input  logic                                   TMS,
  input  logic                                   TDI,
  output logic                                   TDO,
  output logic                                   TDO_EN,
  output logic [IR_WIDTH-1:0]                    JTAG_IR,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_capture,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_update,
  output logic [NUM_USER_DR-1:0]                 user_update_stb
);

  localparam int                UW         = NUM_USER_DR * USER_DR_WIDTH;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  // Opcodes at or above all-ones never select a user register; all-ones is
  // always BYPASS even if the user range would otherwise reach it.
  localparam longint            OP_LIMIT   = (64'd1 << IR_WIDTH) - 64'd1;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SH_DR,
    ST_EX1_DR,
    ST_PAUSE_DR,
    ST_EX2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SH_IR,
    ST_EX1_IR,
    ST_PAUSE_IR,
    ST_EX2_IR,
    ST_UPD_IR
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]      ir_q, ir_d;
  logic                     bypass_q, bypass_d;
  logic [31:0]              idcode_q, idcode_d;
  logic [UW-1:0]            user_sr_q, user_sr_d;
  logic [UW-1:0]            user_upd_q, user_upd_d;
  logic [NUM_USER_DR-1:0]   stb_q, stb_d;
  logic                     tdo_q, tdo_d;
  logic                     tdo_en_q, tdo_en_d;

  logic                     sel_idcode;
  logic [NUM_USER_DR-1:0]   user_hit;
  logic                     tlr_next;
  logic [USER_DR_WIDTH-1:0] slice_tmp;

  // Standard 16-state TAP next-state graph, advanced by TMS on rising TCK.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // The edge that lands in Test-Logic-Reset applies the soft reset, so the
  // IR already reads IDCODE while the state shows TLR.
  assign tlr_next = (state_d == ST_TLR);

  // Instruction decode: IDCODE, one-hot user select, everything else BYPASS.
  always_comb begin
    sel_idcode = (ir_q == OP_IDCODE);
    user_hit   = '0;
    for (int i = 0; i < NUM_USER_DR; i++) begin
      if ((longint'(i) + 64'd2 < OP_LIMIT) && (ir_q == IR_WIDTH'(i + 2))) begin
        user_hit[i] = 1'b1;
      end
    end
  end

  // Instruction register path: capture 01, shift toward LSB, update on UpdIR.
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    if (tlr_next) begin
      ir_sr_d = '0;
      ir_d    = OP_IDCODE;
    end else begin
      case (state_q)
        ST_CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
        ST_SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        ST_UPD_IR: ir_d    = ir_sr_q;
        default:   ;
      endcase
    end
  end

  // Data register bank: only the decoded register captures, shifts or updates.
  always_comb begin
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    user_sr_d  = user_sr_q;
    user_upd_d = user_upd_q;
    stb_d      = '0;
    slice_tmp  = '0;
    if (tlr_next) begin
      bypass_d  = 1'b0;
      idcode_d  = '0;
      user_sr_d = '0;
    end else begin
      case (state_q)
        ST_CAP_DR: begin
          if (sel_idcode) begin
            idcode_d = IDCODE_VAL;
          end else if (|user_hit) begin
            for (int i = 0; i < NUM_USER_DR; i++) begin
              if (user_hit[i]) begin
                user_sr_d[i*USER_DR_WIDTH +: USER_DR_WIDTH] =
                  user_capture[i*USER_DR_WIDTH +: USER_DR_WIDTH];
              end
            end
          end else begin
            bypass_d = 1'b0;
          end
        end
        ST_SH_DR: begin
          if (sel_idcode) begin
            idcode_d = {TDI, idcode_q[31:1]};
          end else if (|user_hit) begin
            for (int i = 0; i < NUM_USER_DR; i++) begin
              if (user_hit[i]) begin
                slice_tmp = user_sr_q[i*USER_DR_WIDTH +: USER_DR_WIDTH] >> 1;
                slice_tmp[USER_DR_WIDTH-1] = TDI;
                user_sr_d[i*USER_DR_WIDTH +: USER_DR_WIDTH] = slice_tmp;
              end
            end
          end else begin
            bypass_d = TDI;
          end
        end
        ST_UPD_DR: begin
          for (int i = 0; i < NUM_USER_DR; i++) begin
            if (user_hit[i]) begin
              user_upd_d[i*USER_DR_WIDTH +: USER_DR_WIDTH] =
                user_sr_q[i*USER_DR_WIDTH +: USER_DR_WIDTH];
              stb_d[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // TDO source selection; only the two Shift states drive real data.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == ST_SH_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == ST_SH_DR) begin
      tdo_en_d = 1'b1;
      if (sel_idcode) begin
        tdo_d = idcode_q[0];
      end else if (|user_hit) begin
        for (int i = 0; i < NUM_USER_DR; i++) begin
          if (user_hit[i]) begin
            tdo_d = user_sr_q[i*USER_DR_WIDTH];
          end
        end
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  // Rising-TCK state: FSM, IR, data registers, update holding regs, strobes.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q    <= ST_TLR;
      ir_sr_q    <= '0;
      ir_q       <= OP_IDCODE;
      bypass_q   <= 1'b0;
      idcode_q   <= '0;
      user_sr_q  <= '0;
      user_upd_q <= '0;
      stb_q      <= '0;
    end else begin
      state_q    <= state_d;
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
      user_sr_q  <= user_sr_d;
      user_upd_q <= user_upd_d;
      stb_q      <= stb_d;
    end
  end

  // Falling-TCK output stage so TDO is stable around the next rising edge.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign TDO             = tdo_q;
  assign TDO_EN          = tdo_en_q;
  assign JTAG_IR         = ir_q;
  assign user_update     = user_upd_q;
  assign user_update_stb = stb_q;

endmodule
